// File: rtl/cruce_peatonal.sv
// Two-street pedestrian crossing controller: Moore FSM with a phase timer and
// latched walk requests that can cut a green phase short after a minimum time.
//
// state      | meaning
// -----------+------------------------------------------
// ROJO_B     | all-red clearance before street A gets green
// A_VERDE    | A green, B red, walk across B
// A_AMARILLO | A amber, B red
// ROJO_A     | all-red clearance before street B gets green
// B_VERDE    | B green, A red, walk across A
// B_AMARILLO | B amber, A red
module cruce_peatonal #(
    parameter int CNT_W       = 8,
    parameter int T_VERDE     = 20,
    parameter int T_VERDE_MIN = 5,
    parameter int T_AMARILLO  = 4,
    parameter int T_ROJO      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic       btn_a,
    input  logic       btn_b,
    output logic [1:0] semaforo_a,
    output logic [1:0] semaforo_b,
    output logic       a_peatonal,
    output logic       b_peatonal,
    output logic [2:0] fase
);

    typedef enum logic [2:0] {
        ROJO_B     = 3'd0,
        A_VERDE    = 3'd1,
        A_AMARILLO = 3'd2,
        ROJO_A     = 3'd3,
        B_VERDE    = 3'd4,
        B_AMARILLO = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] FIN_VERDE    = CNT_W'(T_VERDE - 1);
    localparam logic [CNT_W-1:0] MIN_VERDE    = CNT_W'(T_VERDE_MIN - 1);
    localparam logic [CNT_W-1:0] FIN_AMARILLO = CNT_W'(T_AMARILLO - 1);
    localparam logic [CNT_W-1:0] FIN_ROJO     = CNT_W'(T_ROJO - 1);

    state_t           state;
    state_t           nxt;
    logic             fin;
    logic [CNT_W-1:0] timer;
    logic             req_a;
    logic             req_b;
    logic [5:0]       luces;

    // {semaforo_a, semaforo_b, a_peatonal, b_peatonal} for a given state
    function automatic logic [5:0] decode(input state_t s);
        case (s)
            A_VERDE:    decode = {2'b10, 2'b00, 1'b0, 1'b1};
            A_AMARILLO: decode = {2'b01, 2'b00, 1'b0, 1'b0};
            B_VERDE:    decode = {2'b00, 2'b10, 1'b1, 1'b0};
            B_AMARILLO: decode = {2'b00, 2'b01, 1'b0, 1'b0};
            default:    decode = {2'b00, 2'b00, 1'b0, 1'b0};
        endcase
    endfunction

    always_comb begin
        nxt = ROJO_B;
        fin = 1'b0;
        case (state)
            ROJO_B: begin
                nxt = A_VERDE;
                fin = (timer == FIN_ROJO);
            end
            A_VERDE: begin
                nxt = A_AMARILLO;
                fin = (timer == FIN_VERDE) || (req_a && (timer >= MIN_VERDE));
            end
            A_AMARILLO: begin
                nxt = ROJO_A;
                fin = (timer == FIN_AMARILLO);
            end
            ROJO_A: begin
                nxt = B_VERDE;
                fin = (timer == FIN_ROJO);
            end
            B_VERDE: begin
                nxt = B_AMARILLO;
                fin = (timer == FIN_VERDE) || (req_b && (timer >= MIN_VERDE));
            end
            B_AMARILLO: begin
                nxt = ROJO_B;
                fin = (timer == FIN_AMARILLO);
            end
            default: begin
                nxt = ROJO_B;
                fin = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ROJO_B;
            timer <= '0;
            req_a <= 1'b0;
            req_b <= 1'b0;
            luces <= decode(ROJO_B);
        end else if (enb) begin
            if (btn_a && (state != B_VERDE)) req_a <= 1'b1;
            if (btn_b && (state != A_VERDE)) req_b <= 1'b1;
            if (fin) begin
                state <= nxt;
                timer <= '0;
                luces <= decode(nxt);
                // Serving a request clears it even if the button is pressed on the same edge
                if (nxt == B_VERDE) req_a <= 1'b0;
                if (nxt == A_VERDE) req_b <= 1'b0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign semaforo_a = luces[5:4];
    assign semaforo_b = luces[3:2];
    assign a_peatonal = luces[1];
    assign b_peatonal = luces[0];
    assign fase       = state;

endmodule
